// File: rtl/battle_pkg.sv
// Shared types and defaults for the battleship shot resolver and its board store.
package battle_pkg;

  localparam int unsigned BOARD_DIM_DEF = 5;
  localparam int unsigned MAX_SHIPS_DEF = 3;

  typedef enum logic [2:0] {
    PLACE = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } resolver_state_e;

  typedef struct packed {
    logic hit;
    logic sunk;
    logic repeated;
    logic invalid;
    logic all_sunk;
  } resp_flags_t;

  // True when both coordinates fall inside a dim x dim board.
  function automatic logic coord_ok(input int unsigned row, input int unsigned col,
                                    input int unsigned dim);
    return (row < dim) && (col < dim);
  endfunction

endpackage

// File: rtl/battle_board.sv
// Board cell store: ship id plus shot bit per cell, registered read port, one write port
// and a combinational water probe for placement.
module battle_board
  import battle_pkg::*;
#(
  parameter int unsigned BOARD_DIM = BOARD_DIM_DEF,
  parameter int unsigned CW        = 3,
  parameter int unsigned IW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] probe_row,
  input  logic [CW-1:0] probe_col,
  output logic          probe_water_c,
  input  logic          rd_en,
  input  logic [CW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic          rd_shot,
  output logic [IW-1:0] rd_id,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic          wr_shot,
  input  logic [IW-1:0] wr_id
);

  localparam int unsigned NC = BOARD_DIM * BOARD_DIM;
  localparam int unsigned NW = $clog2(NC);

  logic [IW:0]   cells [NC];
  logic          probe_ok, rd_ok, wr_ok;
  logic [NW-1:0] probe_idx, rd_idx, wr_idx;

  function automatic logic [NW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return NW'(r) * NW'(BOARD_DIM) + NW'(c);
  endfunction

  // Out-of-range coordinates are mapped to cell 0 and masked by the *_ok qualifiers.
  always_comb begin
    probe_ok      = coord_ok(32'(probe_row), 32'(probe_col), BOARD_DIM);
    rd_ok         = coord_ok(32'(rd_row), 32'(rd_col), BOARD_DIM);
    wr_ok         = coord_ok(32'(wr_row), 32'(wr_col), BOARD_DIM);
    probe_idx     = probe_ok ? cell_idx(probe_row, probe_col) : '0;
    rd_idx        = rd_ok ? cell_idx(rd_row, rd_col) : '0;
    wr_idx        = wr_ok ? cell_idx(wr_row, wr_col) : '0;
    probe_water_c = probe_ok && (cells[probe_idx][IW-1:0] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) cells[i] <= '0;
      rd_shot <= 1'b0;
      rd_id   <= '0;
    end else begin
      if (wr_en && wr_ok) cells[wr_idx] <= {wr_shot, wr_id};
      if (rd_en) begin
        if (rd_ok) {rd_shot, rd_id} <= cells[rd_idx];
        else       {rd_shot, rd_id} <= '0;
      end
    end
  end

endmodule

// File: rtl/battle_shot_resolver.sv
// Shot resolver: placement, arming and hit/miss/sunk resolution for one player's board.
// Optional shots_fired statistics output when BATTLE_SHOT_STATS_EN is defined.
module battle_shot_resolver
  import battle_pkg::*;
#(
  parameter int unsigned BOARD_DIM = BOARD_DIM_DEF,
  parameter int unsigned MAX_SHIPS = MAX_SHIPS_DEF,
  localparam int unsigned CW = $clog2(BOARD_DIM),
  localparam int unsigned IW = $clog2(MAX_SHIPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          place_valid,
  input  logic [CW-1:0] place_row,
  input  logic [CW-1:0] place_col,
  input  logic [IW-1:0] place_id,
  output logic          place_ready,
  input  logic          lock,
  input  logic          shot_valid,
  input  logic [CW-1:0] shot_row,
  input  logic [CW-1:0] shot_col,
  output logic          shot_ready,
  output logic          resp_valid,
  output logic          resp_hit,
  output logic          resp_sunk,
  output logic          resp_repeat,
  output logic          resp_invalid,
  output logic          resp_all_sunk,
  output logic [IW-1:0] ships_left,
  output logic          game_over
`ifdef BATTLE_SHOT_STATS_EN
  ,
  output logic [7:0]    shots_fired
`endif
);

  localparam logic [IW-1:0] CNT_MAX = '1;

  resolver_state_e            state;
  resp_flags_t                resp, chk;
  logic [CW-1:0]              shot_r, shot_c;
  logic                       shot_ok;
  logic [MAX_SHIPS:0][IW-1:0] cnt, cnt_nxt;
  logic [IW-1:0]              left_nxt, live;
  logic                       place_ok, probe_water_c, rd_en, rd_shot;
  logic [IW-1:0]              rd_id, wr_id;
  logic                       wr_en, wr_shot;
  logic [CW-1:0]              wr_row, wr_col;

  battle_board #(.BOARD_DIM(BOARD_DIM), .CW(CW), .IW(IW)) u_board (
    .clk           (clk),
    .rst           (rst),
    .probe_row     (place_row),
    .probe_col     (place_col),
    .probe_water_c (probe_water_c),
    .rd_en         (rd_en),
    .rd_row        (shot_row),
    .rd_col        (shot_col),
    .rd_shot       (rd_shot),
    .rd_id         (rd_id),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_shot       (wr_shot),
    .wr_id         (wr_id)
  );

  // Placement writes and shot resolution share the board write port and counter update.
  always_comb begin
    place_ok = (state == PLACE) && place_valid && (place_id != '0) &&
               (32'(place_id) <= MAX_SHIPS) && probe_water_c;
    rd_en    = (state == ARMED) && shot_valid;
    cnt_nxt  = cnt;
    left_nxt = ships_left;
    chk      = '0;
    wr_en    = 1'b0;
    wr_row   = place_row;
    wr_col   = place_col;
    wr_shot  = 1'b0;
    wr_id    = place_id;
    if (place_ok) begin
      wr_en = 1'b1;
      if (cnt[place_id] != CNT_MAX) cnt_nxt[place_id] = cnt[place_id] + IW'(1);
    end
    if (state == CHECK) begin
      wr_row  = shot_r;
      wr_col  = shot_c;
      wr_shot = 1'b1;
      wr_id   = rd_id;
      if (!shot_ok)     chk.invalid  = 1'b1;
      else if (rd_shot) chk.repeated = 1'b1;
      else begin
        wr_en = 1'b1;
        if (rd_id != '0) begin
          chk.hit = 1'b1;
          if (cnt[rd_id] != '0) cnt_nxt[rd_id] = cnt[rd_id] - IW'(1);
          if (cnt[rd_id] == IW'(1)) begin
            chk.sunk = 1'b1;
            if (ships_left != '0)      left_nxt     = ships_left - IW'(1);
            if (ships_left == IW'(1))  chk.all_sunk = 1'b1;
          end
        end
      end
    end
    live = '0;
    for (int i = 1; i <= MAX_SHIPS; i++) begin
      if (cnt_nxt[i] != '0) live = live + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLACE;
      place_ready <= 1'b1;
      shot_ready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp        <= '0;
      ships_left  <= '0;
      game_over   <= 1'b0;
      cnt         <= '0;
      shot_r      <= '0;
      shot_c      <= '0;
      shot_ok     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp       <= '0;
      case (state)
        PLACE: begin
          cnt <= cnt_nxt;
          if (lock) begin
            ships_left  <= live;
            place_ready <= 1'b0;
            if (live == '0) begin
              state     <= DONE;
              game_over <= 1'b1;
            end else begin
              state      <= ARMED;
              shot_ready <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (shot_valid) begin
            shot_r     <= shot_row;
            shot_c     <= shot_col;
            shot_ok    <= coord_ok(32'(shot_row), 32'(shot_col), BOARD_DIM);
            shot_ready <= 1'b0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          cnt        <= cnt_nxt;
          ships_left <= left_nxt;
          resp       <= chk;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp.all_sunk) begin
            state     <= DONE;
            game_over <= 1'b1;
          end else begin
            state      <= ARMED;
            shot_ready <= 1'b1;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

  assign resp_hit      = resp.hit;
  assign resp_sunk     = resp.sunk;
  assign resp_repeat   = resp.repeated;
  assign resp_invalid  = resp.invalid;
  assign resp_all_sunk = resp.all_sunk;

`ifdef BATTLE_SHOT_STATS_EN
  // Counts misses and hits only; invalid and repeat shots do not consume a turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shots_fired <= '0;
    end else if ((state == CHECK) && shot_ok && !rd_shot && (shots_fired != 8'hFF)) begin
      shots_fired <= shots_fired + 8'd1;
    end
  end
`endif

endmodule
